usr_param: RTL and testbench
============================

Name: usr_param

Overview:
- Parametrised universal shift register: hold, logical shift, arithmetic shift, rotate and parallel load on a WIDTH-bit register, with a per-operation shift amount.
- Adds a burst serialiser mode: loads a word, then streams it out LSB-first on s_right_dout under a valid/ready handshake.
- Used as a datapath shifter and as a parallel-to-serial front end for serial links.

Parameters:
- WIDTH, 8, register width in bits; must be >= 2; need not be a power of two.
- AW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- en  input  1  operation enable in IDLE; ready/advance strobe in BURST.
- mode  input  3  operation select; encoding given in Behaviour.
- amt  input  AW  shift/rotate amount for modes 1,2,4,5,6.
- p_din  input  WIDTH  parallel data in.
- s_left_din  input  1  fill bit for left shifts.
- s_right_din  input  1  fill bit for right shifts and for BURST.
- p_dout  output  WIDTH  register contents q.
- s_left_dout  output  1  q[WIDTH-1], combinational from q.
- s_right_dout  output  1  q[0], combinational from q.
- busy  output  1  high while in BURST.
- ser_valid  output  1  s_right_dout carries a valid serial bit; equals busy.
- ser_last  output  1  high when busy and the current bit is the final bit (cnt==0).

Behaviour:
- Reset, asynchronous, any time including mid-burst: q=0, state=IDLE, cnt=0.
  - All outputs read 0 while rst_n is low and on release: p_dout, s_left_dout, s_right_dout, busy, ser_valid, ser_last.
- State machine: IDLE, BURST.
- IDLE, en=0: q holds; mode, amt and data inputs are ignored.
- IDLE, en=1: single-cycle update of q at the next edge, per mode:
  - 0 HOLD: q unchanged.
  - 1 SHR: q >> amt; vacated MSBs filled with s_right_din.
  - 2 SHL: q << amt; vacated LSBs filled with s_left_din.
  - 3 LOAD: q = p_din.
  - 4 ROR: rotate right by amt mod WIDTH.
  - 5 ROL: rotate left by amt mod WIDTH.
  - 6 ASR: q >> amt; vacated MSBs filled with the old q[WIDTH-1].
  - 7 SER: q = p_din, cnt = WIDTH-1, state goes to BURST.
- Shift-amount rules:
  - amt=0 leaves q unchanged in modes 1,2,4,5,6.
  - amt >= WIDTH (only possible when WIDTH is not a power of two): shifts produce all fill bits (ASR gives all old MSB); rotates use the modulo amount.
- BURST:
  - busy=ser_valid=1 and s_right_dout presents the current bit.
  - en=1 consumes the bit: q shifts right by 1 with s_right_din into the MSB, and cnt decrements.
  - en=0 stalls: q and cnt hold, and the bit stays presented.
  - mode, amt and p_din are ignored for the whole burst.
  - ser_last=1 while cnt==0. A consume in that cycle returns to IDLE, so busy falls on the following cycle.
  - Net result: exactly WIDTH bits, p_din[0] first, p_din[WIDTH-1] last. Minimum burst is WIDTH cycles after the load edge.
  - After the burst, q holds the WIDTH s_right_din bits shifted in.
- No back-to-back bursts: an SER request is only accepted in IDLE, so at least one IDLE cycle separates bursts.
- Latency:
  - Parallel ops: result visible on p_dout one edge after the en=1 cycle.
  - Serial outputs follow q with no extra delay.

Test Plan (WIDTH=8):
- Reset mid-operation: LOAD 8'hB5, then assert rst_n=0 between edges -> p_dout=8'h00 and busy=0 immediately, before the next edge. en=0 with mode=3 afterwards -> q stays 8'h00.
- Shifts on 8'hB5:
  - SHL amt=1, s_left_din=1 -> 8'h6B; s_left_dout was 1 before the edge and is 0 after.
  - From a fresh 8'hB5: SHR amt=3, s_right_din=0 -> 8'h16.
  - From a fresh 8'hB5: SHR amt=0 -> 8'hB5.
- Rotates and arithmetic shift:
  - ROR amt=3 on 8'hB5 -> 8'hB6.
  - ROL amt=3 on 8'hB6 -> 8'hB5.
  - ASR amt=2 on 8'h96 -> 8'hE5.
  - ASR amt=7 on 8'h80 -> 8'hFF.
- Burst, en held high: SER with p_din=8'hA5 -> ser_valid high for 8 cycles, bits 1,0,1,0,0,1,0,1. ser_last high only on the 8th bit; busy low the cycle after.
- Burst with stalls: same burst, en low for 2 cycles while bit index 2 is presented -> that bit is held for 2 extra cycles, sequence otherwise unchanged, 10 cycles total. Changing mode/p_din during the burst has no effect.
- Reset mid-burst: rst_n low after the 3rd bit -> ser_valid=0 and q=0 at once. Then, once rst_n is high again, SER 8'h0F -> a fresh 8-bit burst, 1,1,1,1,0,0,0,0.

Source files
------------

// File: rtl/usr_param.sv
// Parametrised universal shift register with a burst serialiser that streams
// a loaded word out LSB-first on s_right_dout under a valid/ready handshake.
module usr_param #(
    parameter int WIDTH = 8,
    localparam int AW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [AW-1:0]    amt,
    input  logic [WIDTH-1:0] p_din,
    input  logic             s_left_din,
    input  logic             s_right_din,
    output logic [WIDTH-1:0] p_dout,
    output logic             s_left_dout,
    output logic             s_right_dout,
    output logic             busy,
    output logic             ser_valid,
    output logic             ser_last
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    localparam logic [2:0] M_HOLD = 3'd0;
    localparam logic [2:0] M_SHR  = 3'd1;
    localparam logic [2:0] M_SHL  = 3'd2;
    localparam logic [2:0] M_LOAD = 3'd3;
    localparam logic [2:0] M_ROR  = 3'd4;
    localparam logic [2:0] M_ROL  = 3'd5;
    localparam logic [2:0] M_ASR  = 3'd6;
    localparam logic [2:0] M_SER  = 3'd7;

    localparam logic [WIDTH-1:0] ONES    = '1;
    localparam logic [AW-1:0]    CNT_MAX = AW'(WIDTH - 1);

    logic [0:0]       state;
    logic [WIDTH-1:0] q;
    logic [AW-1:0]    cnt;
    logic [WIDTH-1:0] next_q;
    int unsigned      rot_amt;

    // Masks make any amount >= WIDTH saturate to all fill bits without a wide intermediate.
    always_comb begin
        next_q  = q;
        rot_amt = 32'(amt) % WIDTH;
        case (mode)
            M_HOLD: next_q = q;
            M_SHR:  next_q = (q >> amt) | (~(ONES >> amt) & {WIDTH{s_right_din}});
            M_SHL:  next_q = (q << amt) | (~(ONES << amt) & {WIDTH{s_left_din}});
            M_LOAD: next_q = p_din;
            M_ROR:  next_q = (q >> rot_amt) | (q << (WIDTH - rot_amt));
            M_ROL:  next_q = (q << rot_amt) | (q >> (WIDTH - rot_amt));
            M_ASR:  next_q = (q >> amt) | (~(ONES >> amt) & {WIDTH{q[WIDTH-1]}});
            M_SER:  next_q = p_din;
            default: next_q = q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            q     <= '0;
            cnt   <= '0;
        end else if (state == IDLE) begin
            if (en) begin
                q <= next_q;
                if (mode == M_SER) begin
                    cnt   <= CNT_MAX;
                    state <= BURST;
                end
            end
        end else if (en) begin
            // Each consumed bit shifts the word toward the serial output.
            q <= {s_right_din, q[WIDTH-1:1]};
            if (cnt == '0) begin
                state <= IDLE;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign p_dout       = q;
    assign s_left_dout  = q[WIDTH-1];
    assign s_right_dout = q[0];
    assign busy         = (state == BURST);
    assign ser_valid    = busy;
    assign ser_last     = busy && (cnt == '0);

endmodule

// File: tb/tb_usr_param.sv
// Directed self-checking bench for usr_param at WIDTH=8: parallel ops,
// burst serialisation with stalls, and asynchronous reset behaviour.
module tb_usr_param;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] mode;
    logic [2:0] amt;
    logic [7:0] p_din;
    logic       s_left_din;
    logic       s_right_din;
    logic [7:0] p_dout;
    logic       s_left_dout;
    logic       s_right_dout;
    logic       busy;
    logic       ser_valid;
    logic       ser_last;

    int testCount;
    int failCount;

    usr_param #(.WIDTH(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .mode(mode),
        .amt(amt),
        .p_din(p_din),
        .s_left_din(s_left_din),
        .s_right_din(s_right_din),
        .p_dout(p_dout),
        .s_left_dout(s_left_dout),
        .s_right_dout(s_right_dout),
        .busy(busy),
        .ser_valid(ser_valid),
        .ser_last(ser_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic e, input logic [2:0] m, input logic [2:0] a,
                                 input logic [7:0] d, input logic sl, input logic sr);
        en          = e;
        mode        = m;
        amt         = a;
        p_din       = d;
        s_left_din  = sl;
        s_right_din = sr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Loads a word in one cycle; the next edge makes it visible on p_dout.
    task automatic loadWord(input logic [7:0] d);
        applyStimulus(1'b1, 3'd3, 3'd0, d, 1'b0, 1'b0);
        step();
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "_pdout"}, 32'(p_dout), 32'h00);
        checkOutput({tag, "_sl"}, 32'(s_left_dout), 32'h0);
        checkOutput({tag, "_sr"}, 32'(s_right_dout), 32'h0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
        checkOutput({tag, "_valid"}, 32'(ser_valid), 32'h0);
        checkOutput({tag, "_last"}, 32'(ser_last), 32'h0);
    endtask

    logic [7:0] bitsA5;
    logic [7:0] bits0F;
    int stallIdx[10];
    logic stallEn[10];

    initial begin
        testCount = 0;
        failCount = 0;
        bitsA5 = 8'hA5;
        bits0F = 8'h0F;
        stallIdx = '{0, 1, 2, 2, 2, 3, 4, 5, 6, 7};
        stallEn  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0;
        applyStimulus(1'b0, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0);
        #3;
        checkIdleZero("rst_low");
        step();
        step();
        rst_n = 1'b1;
        #1;
        checkIdleZero("rst_release");

        // Reset between edges clears q immediately, then en=0 keeps it cleared.
        loadWord(8'hB5);
        checkOutput("load_b5", 32'(p_dout), 32'hB5);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_pdout", 32'(p_dout), 32'h00);
        checkOutput("async_rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 3'd3, 3'd0, 8'hFF, 1'b0, 1'b0);
        step();
        checkOutput("en0_hold", 32'(p_dout), 32'h00);

        loadWord(8'hB5);
        checkOutput("sl_before", 32'(s_left_dout), 32'h1);
        applyStimulus(1'b1, 3'd2, 3'd1, 8'h00, 1'b1, 1'b0);
        step();
        checkOutput("shl1", 32'(p_dout), 32'h6B);
        checkOutput("sl_after", 32'(s_left_dout), 32'h0);

        loadWord(8'hB5);
        applyStimulus(1'b1, 3'd1, 3'd3, 8'h00, 1'b1, 1'b0);
        step();
        checkOutput("shr3", 32'(p_dout), 32'h16);

        loadWord(8'hB5);
        applyStimulus(1'b1, 3'd1, 3'd0, 8'h00, 1'b1, 1'b1);
        step();
        checkOutput("shr0", 32'(p_dout), 32'hB5);

        applyStimulus(1'b1, 3'd4, 3'd3, 8'h00, 1'b1, 1'b1);
        step();
        checkOutput("ror3", 32'(p_dout), 32'hB6);
        applyStimulus(1'b1, 3'd5, 3'd3, 8'h00, 1'b0, 1'b0);
        step();
        checkOutput("rol3", 32'(p_dout), 32'hB5);

        loadWord(8'h96);
        applyStimulus(1'b1, 3'd6, 3'd2, 8'h00, 1'b0, 1'b0);
        step();
        checkOutput("asr2", 32'(p_dout), 32'hE5);
        loadWord(8'h80);
        applyStimulus(1'b1, 3'd6, 3'd7, 8'h00, 1'b0, 1'b0);
        step();
        checkOutput("asr7", 32'(p_dout), 32'hFF);

        // Burst with en held high; ones shifted in so q ends at FF.
        applyStimulus(1'b1, 3'd7, 3'd0, 8'hA5, 1'b0, 1'b1);
        step();
        applyStimulus(1'b1, 3'd0, 3'd0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("b1_valid%0d", i), 32'(ser_valid), 32'h1);
            checkOutput($sformatf("b1_bit%0d", i), 32'(s_right_dout), 32'(bitsA5[i]));
            checkOutput($sformatf("b1_last%0d", i), 32'(ser_last), (i == 7) ? 32'h1 : 32'h0);
            step();
        end
        checkOutput("b1_busy_after", 32'(busy), 32'h0);
        checkOutput("b1_q_after", 32'(p_dout), 32'hFF);
        applyStimulus(1'b0, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0);
        step();

        // Burst with a two-cycle stall on bit 2 while mode/p_din are disturbed.
        applyStimulus(1'b1, 3'd7, 3'd0, 8'hA5, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(stallEn[i], stallEn[i] ? 3'd7 : 3'd3, 3'd5, 8'h3C, 1'b1, 1'b0);
            checkOutput($sformatf("b2_valid%0d", i), 32'(ser_valid), 32'h1);
            checkOutput($sformatf("b2_bit%0d", i), 32'(s_right_dout), 32'(bitsA5[stallIdx[i]]));
            checkOutput($sformatf("b2_last%0d", i), 32'(ser_last), (i == 9) ? 32'h1 : 32'h0);
            step();
        end
        checkOutput("b2_busy_after", 32'(busy), 32'h0);
        checkOutput("b2_q_after", 32'(p_dout), 32'h00);
        applyStimulus(1'b0, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0);
        step();

        // Reset after three consumed bits, then a fresh burst of 0F.
        applyStimulus(1'b1, 3'd7, 3'd0, 8'hA5, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0);
        step();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checkIdleZero("b3_rst");
        rst_n = 1'b1;
        applyStimulus(1'b1, 3'd7, 3'd0, 8'h0F, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("b4_valid%0d", i), 32'(ser_valid), 32'h1);
            checkOutput($sformatf("b4_bit%0d", i), 32'(s_right_dout), 32'(bits0F[i]));
            checkOutput($sformatf("b4_last%0d", i), 32'(ser_last), (i == 7) ? 32'h1 : 32'h0);
            step();
        end
        checkOutput("b4_busy_after", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
